// File: rtl/axi_mem_if.sv
// AXI write/read channel bundle between the streaming DMA master and the
// memory responder. Only the handshake and payload signals are carried here;
// clk and rst stay plain ports on the modules.
//
// Modports:
//   master - drives AW/W/AR payloads, valids and bready/rready
//   slave  - drives awready/wready/arready plus the B and R channels
interface axi_mem_if #(
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256
) ();
  logic                        axi_awvalid;
  logic                        axi_awready;
  logic [AXI_ID_WIDTH-1:0]     axi_awid;
  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr;
  logic [AXI_LEN_WIDTH-1:0]    axi_awlen;
  logic [2:0]                  axi_awsize;
  logic [1:0]                  axi_awburst;

  logic                        axi_wvalid;
  logic                        axi_wready;
  logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                        axi_wlast;

  logic                        axi_bvalid;
  logic                        axi_bready;
  logic [AXI_ID_WIDTH-1:0]     axi_bid;
  logic [1:0]                  axi_bresp;

  logic                        axi_arvalid;
  logic                        axi_arready;
  logic [AXI_ID_WIDTH-1:0]     axi_arid;
  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr;
  logic [AXI_LEN_WIDTH-1:0]    axi_arlen;
  logic [2:0]                  axi_arsize;
  logic [1:0]                  axi_arburst;

  logic                        axi_rvalid;
  logic                        axi_rready;
  logic [AXI_ID_WIDTH-1:0]     axi_rid;
  logic [AXI_DATA_WIDTH-1:0]   axi_rdata;
  logic [1:0]                  axi_rresp;
  logic                        axi_rlast;

  modport master (
    output axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    input  axi_wready,
    input  axi_bvalid, axi_bid, axi_bresp,
    output axi_bready,
    output axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
    input  axi_arready,
    input  axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    output axi_rready
  );

  modport slave (
    input  axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    output axi_wready,
    output axi_bvalid, axi_bid, axi_bresp,
    input  axi_bready,
    input  axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
    output axi_arready,
    output axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    input  axi_rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI responder backed by an internal RAM of 2^MEM_AWIDTH full-width words.
// Serves as bench memory model and on-chip scratch memory.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset (aborts any burst in flight)
//   axi  - slave side of the AXI AW/W/B/AR/R channels (axi_mem_if.slave)
//
// Write and read paths are independent FSMs. Only full-width INCR bursts are
// supported; anything else is still executed as INCR but answered SLVERR.
// Same-word read and write in one cycle returns the old data.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write burst request
// W_DATA | wready high, one RAM write per W beat
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read burst request
// R_DATA | rvalid high, one RAM word per R beat
module axi_mem_slave #(
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int MEM_AWIDTH     = 10
) (
  input logic       clk,
  input logic       rst,
  axi_mem_if.slave  axi
);

  localparam int         STRB_W      = AXI_DATA_WIDTH / 8;
  localparam int         BYTE_LSB    = $clog2(STRB_W);
  localparam logic [2:0] SIZE_FULL   = 3'(BYTE_LSB);
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [AXI_DATA_WIDTH-1:0] mem [0:(1<<MEM_AWIDTH)-1];

  // Upper and sub-word address bits are deliberately ignored (RAM aliases).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.axi_awaddr, axi.axi_araddr};

  // ---------------------------------------------------------------- write
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t w_state, w_state_nxt;

  logic [AXI_ID_WIDTH-1:0]  w_id;
  logic [MEM_AWIDTH-1:0]    w_idx;
  logic [AXI_LEN_WIDTH-1:0] w_len;
  logic [AXI_LEN_WIDTH-1:0] w_cnt;
  logic                     w_err;
  logic                     aw_fire, w_fire, b_fire, w_last_beat;

  assign aw_fire     = axi.axi_awvalid && axi.axi_awready;
  assign w_fire      = axi.axi_wvalid  && axi.axi_wready;
  assign b_fire      = axi.axi_bvalid  && axi.axi_bready;
  assign w_last_beat = (w_cnt == w_len);

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_state_nxt = W_DATA;
      W_DATA:  if (w_fire && w_last_beat) w_state_nxt = W_RESP;
      W_RESP:  if (b_fire) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Gating with rst keeps every ready/valid low for the whole reset cycle,
  // not just from the edge on.
  always_comb begin
    axi.axi_awready = !rst && (w_state == W_IDLE);
    axi.axi_wready  = !rst && (w_state == W_DATA);
    axi.axi_bvalid  = !rst && (w_state == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id  <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else begin
      if (aw_fire) begin
        w_id  <= axi.axi_awid;
        w_idx <= axi.axi_awaddr[BYTE_LSB +: MEM_AWIDTH];
        w_len <= axi.axi_awlen;
        w_cnt <= '0;
        w_err <= (axi.axi_awburst != BURST_INCR) || (axi.axi_awsize != SIZE_FULL);
      end
      if (w_fire) begin
        w_idx <= w_idx + MEM_AWIDTH'(1);
        w_cnt <= w_cnt + AXI_LEN_WIDTH'(1);
        // Burst length comes from awlen; wlast is only checked, not obeyed.
        if (axi.axi_wlast != w_last_beat) w_err <= 1'b1;
      end
    end
  end

  // w_id and w_err are frozen in W_RESP, so bid/bresp hold until bready.
  assign axi.axi_bid   = w_id;
  assign axi.axi_bresp = w_err ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= axi.axi_wdata[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t r_state, r_state_nxt;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [MEM_AWIDTH-1:0]     r_idx;
  logic [MEM_AWIDTH-1:0]     r_idx_inc;
  logic [AXI_LEN_WIDTH-1:0]  r_len;
  logic [AXI_LEN_WIDTH-1:0]  r_cnt;
  logic                      r_err;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic                      ar_fire, r_fire, r_last_beat;

  assign ar_fire     = axi.axi_arvalid && axi.axi_arready;
  assign r_fire      = axi.axi_rvalid  && axi.axi_rready;
  assign r_last_beat = (r_cnt == r_len);
  assign r_idx_inc   = r_idx + MEM_AWIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_nxt = R_DATA;
      R_DATA:  if (r_fire && r_last_beat) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    axi.axi_arready = !rst && (r_state == R_IDLE);
    axi.axi_rvalid  = !rst && (r_state == R_DATA);
    axi.axi_rlast   = !rst && (r_state == R_DATA) && r_last_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id  <= '0;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (ar_fire) begin
      r_id  <= axi.axi_arid;
      r_idx <= axi.axi_araddr[BYTE_LSB +: MEM_AWIDTH];
      r_len <= axi.axi_arlen;
      r_cnt <= '0;
      r_err <= (axi.axi_arburst != BURST_INCR) || (axi.axi_arsize != SIZE_FULL);
    end else if (r_fire && !r_last_beat) begin
      r_idx <= r_idx_inc;
      r_cnt <= r_cnt + AXI_LEN_WIDTH'(1);
    end
  end

  // Separate process from the RAM write, so a same-edge write to the word
  // being fetched is not yet visible: read-first behaviour.
  always_ff @(posedge clk) begin
    if (ar_fire)                     rdata_q <= mem[axi.axi_araddr[BYTE_LSB +: MEM_AWIDTH]];
    else if (r_fire && !r_last_beat) rdata_q <= mem[r_idx_inc];
  end

  assign axi.axi_rid   = r_id;
  assign axi.axi_rdata = rdata_q;
  assign axi.axi_rresp = r_err ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;

  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_mem_if #(.AXI_ID_WIDTH(8), .AXI_LEN_WIDTH(8), .AXI_ADDR_WIDTH(32),
               .AXI_DATA_WIDTH(DW)) bus ();

  axi_mem_slave #(.AXI_ID_WIDTH(8), .AXI_LEN_WIDTH(8), .AXI_ADDR_WIDTH(32),
                  .AXI_DATA_WIDTH(DW), .MEM_AWIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .axi (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [0:1023];

  typedef struct {
    logic [7:0]    id;
    logic [31:0]   addr;
    logic [7:0]    len;
    logic [1:0]    burst;
    logic [2:0]    size;
    int            wlast_beat;
    logic [DW-1:0] data0;
    logic [31:0]   strb;
    logic [1:0]    exp_bresp;
    logic [1:0]    exp_rresp;
  } wvec_t;

  wvec_t vecs [8];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr, input int beat);
    return int'((addr >> 5) + 32'(beat)) & 1023;
  endfunction

  task automatic do_write(input wvec_t v, input string nm);
    int n;
    bus.axi_awvalid = 1'b1;
    bus.axi_awid    = v.id;
    bus.axi_awaddr  = v.addr;
    bus.axi_awlen   = v.len;
    bus.axi_awsize  = v.size;
    bus.axi_awburst = v.burst;
    bus.axi_bready  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.axi_awready && n < 50) begin n++; @(negedge clk); end
    chk({nm, "_aw_timeout"}, bus.axi_awready, 1'b1);
    @(posedge clk); #1;
    bus.axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      bus.axi_wvalid = 1'b1;
      bus.axi_wdata  = v.data0 + DW'(b);
      bus.axi_wstrb  = v.strb;
      bus.axi_wlast  = (b == v.wlast_beat);
      n = 0;
      @(negedge clk);
      if (b == 0) chk({nm, "_wready_latency"}, bus.axi_wready, 1'b1);
      while (!bus.axi_wready && n < 50) begin n++; @(negedge clk); end
      if (!bus.axi_wready) begin
        chk({nm, "_w_timeout"}, bus.axi_wready, 1'b1);
        break;
      end
      for (int k = 0; k < 32; k++)
        if (v.strb[k]) model[widx(v.addr, b)][k*8 +: 8] = bus.axi_wdata[k*8 +: 8];
      @(posedge clk); #1;
    end
    bus.axi_wvalid = 1'b0;
    bus.axi_wlast  = 1'b0;
    @(negedge clk);
    chk({nm, "_bvalid_latency"}, bus.axi_bvalid, 1'b1);
    chk({nm, "_bid"}, bus.axi_bid, v.id);
    chk({nm, "_bresp"}, bus.axi_bresp, v.exp_bresp);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_bvalid_hold"}, bus.axi_bvalid, 1'b1);
    chk({nm, "_bresp_hold"}, bus.axi_bresp, v.exp_bresp);
    @(posedge clk); #1;
    bus.axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.axi_bready = 1'b0;
    @(negedge clk);
    chk({nm, "_bvalid_clear"}, bus.axi_bvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input logic [1:0] exp_resp,
                         input logic [3:0] rpat, input string nm, output logic [DW-1:0] first);
    int n, c, beats;
    bit stalled, done;
    logic [DW-1:0] prev_d;
    logic prev_l;
    first = '0;
    bus.axi_arvalid = 1'b1;
    bus.axi_arid    = id;
    bus.axi_araddr  = addr;
    bus.axi_arlen   = len;
    bus.axi_arsize  = size;
    bus.axi_arburst = burst;
    n = 0;
    @(negedge clk);
    while (!bus.axi_arready && n < 50) begin n++; @(negedge clk); end
    chk({nm, "_ar_timeout"}, bus.axi_arready, 1'b1);
    @(posedge clk); #1;
    bus.axi_arvalid = 1'b0;
    c = 0; beats = 0; stalled = 0; done = 0; prev_d = '0; prev_l = 1'b0;
    bus.axi_rready = rpat[0];
    while (!done && c < 200) begin
      @(negedge clk);
      if (c == 0) chk({nm, "_rvalid_latency"}, bus.axi_rvalid, 1'b1);
      if (bus.axi_rvalid && stalled) begin
        chk({nm, "_stall_rdata"}, bus.axi_rdata, prev_d);
        chk({nm, "_stall_rlast"}, bus.axi_rlast, prev_l);
      end
      if (bus.axi_rvalid && bus.axi_rready) begin
        chk($sformatf("%s_rdata%0d", nm, beats), bus.axi_rdata, model[widx(addr, beats)]);
        chk($sformatf("%s_rlast%0d", nm, beats), bus.axi_rlast, beats == int'(len));
        chk({nm, "_rid"}, bus.axi_rid, id);
        chk({nm, "_rresp"}, bus.axi_rresp, exp_resp);
        if (beats == 0) first = bus.axi_rdata;
        if (bus.axi_rlast || beats >= int'(len)) done = 1;
        beats++;
      end
      stalled = bus.axi_rvalid && !bus.axi_rready;
      prev_d  = bus.axi_rdata;
      prev_l  = bus.axi_rlast;
      @(posedge clk); #1;
      c++;
      bus.axi_rready = rpat[c % 4];
    end
    bus.axi_rready = 1'b0;
    chk({nm, "_beats"}, beats, int'(len) + 1);
  endtask

  logic [DW-1:0] first_d;
  logic [DW-1:0] old_d [4];
  localparam logic [DW-1:0] EXP_STRB = {{31{8'hFF}}, 8'h00};

  initial begin
    bus.axi_awvalid = 0; bus.axi_awid = 0; bus.axi_awaddr = 0; bus.axi_awlen = 0;
    bus.axi_awsize = 0; bus.axi_awburst = 0; bus.axi_wvalid = 0; bus.axi_wdata = 0;
    bus.axi_wstrb = 0; bus.axi_wlast = 0; bus.axi_bready = 0; bus.axi_arvalid = 0;
    bus.axi_arid = 0; bus.axi_araddr = 0; bus.axi_arlen = 0; bus.axi_arsize = 0;
    bus.axi_arburst = 0; bus.axi_rready = 0;
    for (int i = 0; i < 1024; i++) model[i] = '0;

    //          id     addr          len   burst  size  wlast data0        strb           bresp  rresp
    vecs[0] = '{8'h5A, 32'h0000_0040, 8'd3, 2'b01, 3'd5, 3, DW'(1),      32'hFFFF_FFFF, 2'b00, 2'b00};
    vecs[1] = '{8'h01, 32'h0000_0000, 8'd0, 2'b01, 3'd5, 0, '1,          32'hFFFF_FFFF, 2'b00, 2'b00};
    vecs[2] = '{8'h02, 32'h0000_0000, 8'd0, 2'b01, 3'd5, 0, DW'(0),      32'h0000_0001, 2'b00, 2'b00};
    vecs[3] = '{8'h03, 32'h0000_7FC0, 8'd3, 2'b01, 3'd5, 3, DW'('h100),  32'hFFFF_FFFF, 2'b00, 2'b00};
    vecs[4] = '{8'h04, 32'h0000_0200, 8'd1, 2'b10, 3'd5, 1, DW'('hA0),   32'hFFFF_FFFF, 2'b10, 2'b10};
    vecs[5] = '{8'h05, 32'h0000_0400, 8'd3, 2'b01, 3'd5, 1, DW'('hC0),   32'hFFFF_FFFF, 2'b10, 2'b00};
    vecs[6] = '{8'h06, 32'h0000_0800, 8'd1, 2'b01, 3'd2, 1, DW'('hD0),   32'hFFFF_FFFF, 2'b10, 2'b10};
    vecs[7] = '{8'h07, 32'h8000_0067, 8'd0, 2'b01, 3'd5, 0, DW'('hE0),   32'h0000_FFFF, 2'b00, 2'b00};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", bus.axi_awready, 1'b0);
    chk("rst_wready",  bus.axi_wready,  1'b0);
    chk("rst_bvalid",  bus.axi_bvalid,  1'b0);
    chk("rst_arready", bus.axi_arready, 1'b0);
    chk("rst_rvalid",  bus.axi_rvalid,  1'b0);
    chk("rst_rlast",   bus.axi_rlast,   1'b0);
    chk("rst_ids",     {bus.axi_bid, bus.axi_rid}, 16'h0);
    chk("rst_resps",   {bus.axi_bresp, bus.axi_rresp}, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", bus.axi_awready, 1'b1);
    chk("post_rst_arready", bus.axi_arready, 1'b1);
    @(posedge clk); #1;

    // table-driven write + readback
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i], $sformatf("v%0d_wr", i));
      do_read(vecs[i].id ^ 8'hFF, vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].size,
              vecs[i].exp_rresp, 4'b1111, $sformatf("v%0d_rd", i), first_d);
      if (i == 0) chk("basic_first_beat", first_d, DW'(1));
      if (i == 2) chk("strobe_word0", first_d, EXP_STRB);
      if (i == 3) begin
        do_read(8'h30, 32'h0, 8'd0, 2'b01, 3'd5, 2'b00, 4'b1111, "wrap_word0", first_d);
        chk("wrap_word0_value", first_d, DW'('h102));
      end
    end

    // backpressure: rready 1,0,0,1
    do_read(8'h33, 32'h40, 8'd3, 2'b01, 3'd5, 2'b00, 4'b1001, "bp", first_d);

    // concurrent write and read on words 40..43, read one cycle behind
    do_write('{8'h40, 32'h500, 8'd3, 2'b01, 3'd5, 3, DW'('hA0A0_0000), 32'hFFFF_FFFF, 2'b00, 2'b00}, "cc_pre");
    for (int k = 0; k < 4; k++) old_d[k] = model[40 + k];
    begin
      int wb, rb, cyc;
      bit b_done, ar_sent, aw_hs, w_hs, ar_hs, r_hs, b_hs;
      bus.axi_awvalid = 1; bus.axi_awid = 8'h41; bus.axi_awaddr = 32'h500; bus.axi_awlen = 3;
      bus.axi_awsize = 3'd5; bus.axi_awburst = 2'b01;
      bus.axi_wvalid = 1; bus.axi_wdata = DW'('hB0B0_0000); bus.axi_wstrb = '1; bus.axi_wlast = 0;
      bus.axi_rready = 1; bus.axi_bready = 1;
      wb = 0; rb = 0; cyc = 0; b_done = 0; ar_sent = 0;
      while ((rb < 4 || !b_done) && cyc < 40) begin
        @(negedge clk);
        if (cyc == 0) chk("cc_w_before_aw", bus.axi_wready, 1'b0);
        aw_hs = bus.axi_awvalid && bus.axi_awready;
        w_hs  = bus.axi_wvalid  && bus.axi_wready;
        ar_hs = bus.axi_arvalid && bus.axi_arready;
        r_hs  = bus.axi_rvalid  && bus.axi_rready;
        b_hs  = bus.axi_bvalid  && bus.axi_bready;
        if (r_hs && rb < 4) begin
          chk($sformatf("cc_old_rdata%0d", rb), bus.axi_rdata, old_d[rb]);
          chk($sformatf("cc_rlast%0d", rb), bus.axi_rlast, rb == 3);
          rb++;
        end
        if (b_hs) begin
          chk("cc_bresp", bus.axi_bresp, 2'b00);
          chk("cc_bid", bus.axi_bid, 8'h41);
          b_done = 1;
        end
        if (w_hs) model[40 + wb] = bus.axi_wdata;
        @(posedge clk); #1;
        if (aw_hs) begin
          bus.axi_awvalid = 0;
          if (!ar_sent) begin
            bus.axi_arvalid = 1; bus.axi_arid = 8'h77; bus.axi_araddr = 32'h500;
            bus.axi_arlen = 3; bus.axi_arsize = 3'd5; bus.axi_arburst = 2'b01;
            ar_sent = 1;
          end
        end
        if (ar_hs) bus.axi_arvalid = 0;
        if (w_hs) begin
          wb++;
          if (wb < 4) begin
            bus.axi_wdata = DW'('hB0B0_0000) + DW'(wb);
            bus.axi_wlast = (wb == 3);
          end else begin
            bus.axi_wvalid = 0;
            bus.axi_wlast  = 0;
          end
        end
        cyc++;
      end
      bus.axi_rready = 0; bus.axi_bready = 0; bus.axi_awvalid = 0; bus.axi_arvalid = 0;
      bus.axi_wvalid = 0;
      chk("cc_r_beats", rb, 4);
      chk("cc_b_done", b_done, 1'b1);
      chk("cc_w_beats", wb, 4);
    end
    do_read(8'h78, 32'h500, 8'd3, 2'b01, 3'd5, 2'b00, 4'b1111, "cc_new", first_d);
    chk("cc_new_first", first_d, DW'('hB0B0_0000));

    // reset during W_DATA after two beats to words 50,51
    begin
      int n;
      bit saw_b;
      bus.axi_awvalid = 1; bus.axi_awid = 8'h50; bus.axi_awaddr = 32'h640; bus.axi_awlen = 3;
      bus.axi_awsize = 3'd5; bus.axi_awburst = 2'b01;
      n = 0;
      @(negedge clk);
      while (!bus.axi_awready && n < 50) begin n++; @(negedge clk); end
      @(posedge clk); #1;
      bus.axi_awvalid = 0;
      for (int b = 0; b < 2; b++) begin
        bus.axi_wvalid = 1; bus.axi_wdata = DW'('h5000 + b); bus.axi_wstrb = '1; bus.axi_wlast = 0;
        @(negedge clk);
        chk($sformatf("rst_wr_wready%0d", b), bus.axi_wready, 1'b1);
        if (bus.axi_wready) model[50 + b] = bus.axi_wdata;
        @(posedge clk); #1;
      end
      bus.axi_wvalid = 0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_outputs", {bus.axi_awready, bus.axi_wready, bus.axi_bvalid,
                              bus.axi_arready, bus.axi_rvalid}, 5'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_next_outputs", {bus.axi_awready, bus.axi_wready, bus.axi_bvalid,
                                   bus.axi_arready, bus.axi_rvalid}, 5'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      saw_b = 0;
      @(negedge clk);
      chk("after_abort_awready", bus.axi_awready, 1'b1);
      chk("after_abort_wready", bus.axi_wready, 1'b0);
      for (int k = 0; k < 10; k++) begin
        if (bus.axi_bvalid) saw_b = 1;
        @(negedge clk);
      end
      chk("after_abort_no_bvalid", saw_b, 1'b0);
      @(posedge clk); #1;
    end
    do_read(8'h51, 32'h640, 8'd1, 2'b01, 3'd5, 2'b00, 4'b1111, "abort_kept", first_d);
    chk("abort_kept_first", first_d, DW'('h5000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
